reg_rd_port_16: RTL

Read side of the 16-entry CPU register file, the counterpart of the write-enable decoder. It accepts a two-operand read request (A and B addresses) and selects both operands from the register bank. It forwards same-cycle writes and presents the operands to the ALU stage through a one-deep registered valid/ready output. Held operands are kept coherent with writes that land while the consumer stalls.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/reg_rd_sel.sv | 31 +++
 rtl/reg_rd_port_16.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file constants and types for the CPU read/write ports.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Output stage occupancy of the read port.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/reg_rd_sel.sv
// One operand selector: picks a register from the flat bank, bypassing a
// same-cycle write to the same register. Register 0 optionally reads as zero.
module reg_rd_sel
  import cpu_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b0
) (
  input  reg_addr_t                addr,
  input  logic [NREG*DATA_W-1:0]   regs_flat,
  input  logic                     wr_en,
  input  reg_addr_t                wr_addr,
  input  reg_data_t                wr_data,
  output reg_data_t                value,
  output logic                     fwd
);

  // Priority: hard-wired zero, then write bypass, then the bank itself.
  always_comb begin
    value = regs_flat[int'(addr) * DATA_W +: DATA_W];
    fwd   = 1'b0;
    if (wr_en && (wr_addr == addr)) begin
      value = wr_data;
      fwd   = 1'b1;
    end
    if (ZERO_R0 && (addr == '0)) begin
      value = '0;
      fwd   = 1'b0;
    end
  end

endmodule

// File: rtl/reg_rd_port_16.sv
// Two-operand register-file read port with write forwarding and a one-deep
// registered valid/ready output stage. Held operands track writes to their
// registers while the consumer stalls.
//
// Handshake: a request transfers on a rising edge where rd_req && rd_req_ready;
// an operand pair transfers where rd_valid && rd_ready. rd_req_ready is
// !rd_valid || rd_ready, so the stage can drain and refill in one cycle, and
// rd_valid only falls after the consumer has taken the pair.
module reg_rd_port_16
  import cpu_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_req,
  output logic                     rd_req_ready,
  input  reg_addr_t                rd_addr_a,
  input  reg_addr_t                rd_addr_b,
  input  logic [NREG*DATA_W-1:0]   regs_flat,
  input  logic                     wr_en,
  input  reg_addr_t                wr_addr,
  input  reg_data_t                wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output reg_data_t                rd_data_a,
  output reg_data_t                rd_data_b,
  output logic                     rd_fwd_a,
  output logic                     rd_fwd_b,
  output rd_state_e                state
);

  rd_state_e state_nxt;
  reg_addr_t held_a;
  reg_addr_t held_b;
  reg_addr_t sel_addr_a;
  reg_addr_t sel_addr_b;
  reg_data_t sel_val_a;
  reg_data_t sel_val_b;
  logic      sel_fwd_a;
  logic      sel_fwd_b;
  logic      accept;
  logic      hold;

  assign rd_valid     = (state == ST_FULL);
  assign rd_req_ready = !rd_valid || rd_ready;
  assign accept       = rd_req && rd_req_ready;
  assign hold         = rd_valid && !rd_ready;

  // While holding, the selectors watch the held registers so a write to one
  // of them can refresh the stalled operand; otherwise they serve the request.
  always_comb begin
    sel_addr_a = hold ? held_a : rd_addr_a;
    sel_addr_b = hold ? held_b : rd_addr_b;
  end

  reg_rd_sel #(.ZERO_R0(ZERO_R0)) u_sel_a (
    .addr      (sel_addr_a),
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .value     (sel_val_a),
    .fwd       (sel_fwd_a)
  );

  reg_rd_sel #(.ZERO_R0(ZERO_R0)) u_sel_b (
    .addr      (sel_addr_b),
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .value     (sel_val_b),
    .fwd       (sel_fwd_b)
  );

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Next occupancy: fill on a request, empty when drained with nothing new.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (rd_req) state_nxt = ST_FULL;
      ST_FULL:  if (rd_ready && !rd_req) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Operand/address capture on accept; stall-time refresh from writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_fwd_a  <= 1'b0;
      rd_fwd_b  <= 1'b0;
      held_a    <= '0;
      held_b    <= '0;
    end else if (accept) begin
      rd_data_a <= sel_val_a;
      rd_data_b <= sel_val_b;
      rd_fwd_a  <= sel_fwd_a;
      rd_fwd_b  <= sel_fwd_b;
      held_a    <= rd_addr_a;
      held_b    <= rd_addr_b;
    end else if (hold) begin
      if (sel_fwd_a) begin
        rd_data_a <= sel_val_a;
        rd_fwd_a  <= 1'b1;
      end
      if (sel_fwd_b) begin
        rd_data_b <= sel_val_b;
        rd_fwd_b  <= 1'b1;
      end
    end
  end

endmodule
